simd_wb_buffer: RTL and testbench
=================================

# simd_wb_buffer

Writeback buffer for the 64-bit SIMD execute stage. It accepts one result per cycle from the execute-stage result mux, which carries the shifter's `shift_out` and the ALU result. It applies the instruction's participation field (PPP) to build a per-byte write mask, and holds up to two results in a FIFO. It drains them to the register-file write port and stalls whenever that port is busy. The newest buffered result is also presented on a forwarding port for the decode/operand stage.

## Interface
- `DATA_W`, 64, datapath width; bit 0 is MSB, numbered `[0:DATA_W-1]`; must be a multiple of 8
- `ADDR_W`, 5, register-address width
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  execute result present this cycle
- `in_ready`  out  1  buffer can accept this cycle
- `in_data`  in  `[0:DATA_W-1]`  result (shifter/ALU output)
- `in_rd`  in  `[0:ADDR_W-1]`  destination register
- `in_wren`  in  1  instruction writes a register
- `in_ppp`  in  `[0:2]`  participation field
- `wb_stall`  in  1  register-file write port unavailable this cycle
- `wb_en`  out  1  register-file write strobe
- `wb_addr`  out  `[0:ADDR_W-1]`  write address
- `wb_data`  out  `[0:DATA_W-1]`  write data
- `wb_byte_en`  out  `[0:DATA_W/8-1]`  byte write enables; bit k covers data bits `[8k:8k+7]`
- `fwd_valid`  out  1  forwarding entry valid
- `fwd_rd`  out  `[0:ADDR_W-1]`  forwarding destination
- `fwd_data`  out  `[0:DATA_W-1]`  forwarding data
- `fwd_byte_en`  out  `[0:DATA_W/8-1]`  forwarding byte mask
- `count`  out  2  entries held (0..2)

## Operation
- Storage: 2-entry FIFO. Each entry holds data, rd and the byte mask. Read and write pointers are 1 bit each and wrap 1→0. `count` is the occupancy.
- Mask decode at acceptance (byte 0 = bits `[0:7]`, MSB), for `DATA_W`=64:
  - 000 → all bytes, `11111111`
  - 001 → upper half, bytes 0-3, `11110000`
  - 010 → lower half, bytes 4-7, `00001111`
  - 011 → even bytes, `10101010`
  - 100 → odd bytes, `01010101`
  - 101/110/111 → `00000000`
- Generalisation: upper/lower = first/second `DATA_W/16` bytes.
- Acceptance: `accept = in_valid & in_ready`.
- Drop rule: an accepted result with `in_wren`=0 or a zero mask is consumed but not stored. `count` and pointers are unchanged for it.
- `in_ready` = (`count` != 2), combinational from state only. It is independent of `wb_stall` and `in_valid`. A full buffer does not accept even if it pops in the same cycle.
- Drain: `wb_en` = (`count` != 0) & !`wb_stall`. `wb_addr`, `wb_data` and `wb_byte_en` come from the head entry and are driven continuously from it even when `wb_en`=0. The head is popped at the edge where `wb_en`=1.
- Simultaneous push and pop at `count`=1: the head pops, the new entry is written to the tail slot, and `count` stays 1.
- Forwarding: `fwd_*` show the newest stored entry (the tail). If both entries target the same rd, the newest wins. `fwd_valid` = (`count` != 0).
- `fwd_*` do not include the entry being accepted this cycle.
- There is no data merging. Partial-mask entries are written to the register file in FIFO order. The consumer merges `fwd_data` using `fwd_byte_en`.

## Timing
- Reset (asynchronous, immediate):
  - `count`=0 and pointers=0.
  - All storage cleared to 0.
  - `wb_en`=0, `wb_addr`=0, `wb_data`=0, `wb_byte_en`=0.
  - `fwd_valid`=0, `fwd_rd`=0, `fwd_data`=0, `fwd_byte_en`=0.
  - `in_ready`=1.
- Reset mid-operation discards all buffered entries. Nothing is written after reset asserts.
- Latency: an entry accepted at edge N into an empty buffer drives `wb_*`/`fwd_*` in cycle N+1. It writes at edge N+1 if `wb_stall`=0.
- Throughput: 1 result/cycle sustained while `wb_stall`=0. Occupancy never exceeds 1 in that case.
- `wb_stall` held: the buffer fills after two accepted writes and `in_ready` drops in the cycle after the second accept. On stall release, entries drain one per cycle in acceptance order.
- All outputs except `in_ready` and `wb_en` are registered-state outputs. `in_ready` and `wb_en` are combinational from state and `wb_stall` only; there is no combinational path from `in_*` to any output.

## Test plan
- Reset/idle:
  - stimulus: assert `reset` mid-cycle with `count`=2
  - required response: all outputs 0 at once, `in_ready`=1; after deassert, no `wb_en` pulse
- Single write:
  - stimulus: `in_data`=0x0123456789ABCDEF, rd=7, ppp=000, wren=1, `wb_stall`=0
  - required response: next cycle `wb_en`=1, `wb_addr`=7, `wb_byte_en`=`11111111`, data matches; `count` back to 0 after that edge
- PPP decode:
  - stimulus: ppp 001/010/011/100 with rd=3
  - required response: masks `11110000`/`00001111`/`10101010`/`01010101`
  - stimulus: ppp=101, or wren=0
  - required response: `count` stays 0, no `wb_en`
- Stall and fill:
  - stimulus: `wb_stall`=1; push rd=1, then rd=2, then rd=3
  - required response: `count`=2 and `in_ready`=0, so the rd=3 push is not accepted; `fwd_rd`=2
  - stimulus: release stall
  - required response: writes rd=1 then rd=2 on consecutive cycles
- Same-cycle push/pop:
  - stimulus: `count`=1 (rd=4), `wb_stall`=0, push rd=5
  - required response: rd=4 written; `count`=1; `fwd_rd`=5
- Forwarding hazard:
  - stimulus: stall; push rd=9 ppp=001 data A, then rd=9 ppp=010 data B
  - required response: `fwd_data`=B with `fwd_byte_en`=`00001111`; after release, two writes occur in order

Source files
------------

// File: rtl/simd_wb_buffer.sv
`default_nettype none
// ============================================================================
// simd_wb_buffer : two-entry writeback FIFO between the SIMD execute stage
//                  and the register-file write port, with newest-entry forward.
// Revision 1.0
// ============================================================================
module simd_wb_buffer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:DATA_W-1]     in_data,
    input  logic [0:ADDR_W-1]     in_rd,
    input  logic                  in_wren,
    input  logic [0:2]            in_ppp,
    input  logic                  wb_stall,
    output logic                  wb_en,
    output logic [0:ADDR_W-1]     wb_addr,
    output logic [0:DATA_W-1]     wb_data,
    output logic [0:DATA_W/8-1]   wb_byte_en,
    output logic                  fwd_valid,
    output logic [0:ADDR_W-1]     fwd_rd,
    output logic [0:DATA_W-1]     fwd_data,
    output logic [0:DATA_W/8-1]   fwd_byte_en,
    output logic [1:0]            count
);

    localparam int c_NBYTES = DATA_W / 8;
    localparam int c_HALF   = DATA_W / 16;

    logic [0:DATA_W-1]   data_q [0:1];
    logic [0:ADDR_W-1]   rd_q   [0:1];
    logic [0:c_NBYTES-1] be_q   [0:1];
    logic                wptr_q;
    logic                rptr_q;
    logic [1:0]          count_q;
    logic [1:0]          count_d;

    logic [0:c_NBYTES-1] w_mask;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_tail;

    // Byte 0 is the most significant byte; "upper" means the leading half.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < c_NBYTES; k++) begin
            case (in_ppp)
                3'b000:  w_mask[k] = 1'b1;
                3'b001:  w_mask[k] = (k < c_HALF);
                3'b010:  w_mask[k] = (k >= c_HALF);
                3'b011:  w_mask[k] = ((k % 2) == 0);
                3'b100:  w_mask[k] = ((k % 2) == 1);
                default: w_mask[k] = 1'b0;
            endcase
        end
    end

    assign in_ready = (count_q != 2'd2);
    assign w_accept = in_valid & in_ready;
    // Non-writing or fully masked results are consumed without occupying a slot.
    assign w_push   = w_accept & in_wren & (|w_mask);
    assign wb_en    = (count_q != 2'd0) & ~wb_stall;
    assign w_pop    = wb_en;
    assign w_tail   = ~wptr_q;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= 2'd0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            rd_q[0]   <= '0;
            rd_q[1]   <= '0;
            be_q[0]   <= '0;
            be_q[1]   <= '0;
        end else begin
            count_q <= count_d;
            if (w_push) begin
                data_q[wptr_q] <= in_data;
                rd_q[wptr_q]   <= in_rd;
                be_q[wptr_q]   <= w_mask;
                wptr_q         <= ~wptr_q;
            end
            if (w_pop) begin
                rptr_q <= ~rptr_q;
            end
        end
    end

    assign wb_addr     = rd_q[rptr_q];
    assign wb_data     = data_q[rptr_q];
    assign wb_byte_en  = be_q[rptr_q];

    // The slot just behind the write pointer always holds the newest entry.
    assign fwd_valid   = (count_q != 2'd0);
    assign fwd_rd      = rd_q[w_tail];
    assign fwd_data    = data_q[w_tail];
    assign fwd_byte_en = be_q[w_tail];

    assign count       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_simd_wb_buffer.sv
`default_nettype none
// ============================================================================
// tb_simd_wb_buffer : directed table, corner sequences and random traffic
//                     against a queue-based model of the writeback buffer.
// Revision 1.0
// ============================================================================
module tb_simd_wb_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [0:63] in_data = '0;
    logic [0:4]  in_rd = '0;
    logic        in_wren = 1'b0;
    logic [0:2]  in_ppp = '0;
    logic        wb_stall = 1'b0;
    logic        wb_en;
    logic [0:4]  wb_addr;
    logic [0:63] wb_data;
    logic [0:7]  wb_byte_en;
    logic        fwd_valid;
    logic [0:4]  fwd_rd;
    logic [0:63] fwd_data;
    logic [0:7]  fwd_byte_en;
    logic [1:0]  count;

    simd_wb_buffer #(.DATA_W(64), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_rd(in_rd), .in_wren(in_wren), .in_ppp(in_ppp),
        .wb_stall(wb_stall), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_byte_en(wb_byte_en),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .fwd_byte_en(fwd_byte_en), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:4]  rd;
        logic [0:63] data;
        logic [0:7]  be;
    } ent_t;

    typedef struct {
        logic [2:0] ppp;
        logic       wren;
        logic [7:0] be;
        logic       store;
    } vec_t;

    ent_t        q[$];
    vec_t        vecs[8];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        obs_wb_en;
    logic [0:4]  obs_wb_addr;
    logic [0:63] obs_wb_data;
    logic [0:7]  obs_wb_be;

    function automatic logic [7:0] model_mask(input logic [2:0] ppp);
        case (ppp)
            3'd0:    return 8'hFF;
            3'd1:    return 8'hF0;
            3'd2:    return 8'h0F;
            3'd3:    return 8'hAA;
            3'd4:    return 8'h55;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        check("in_ready", in_ready, q.size() != 2);
        check("wb_en", wb_en, (q.size() != 0) && !wb_stall);
        check("count", count, q.size());
        check("fwd_valid", fwd_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("wb_addr", wb_addr, q[0].rd);
            check("wb_data", wb_data, q[0].data);
            check("wb_byte_en", wb_byte_en, q[0].be);
            check("fwd_rd", fwd_rd, q[$].rd);
            check("fwd_data", fwd_data, q[$].data);
            check("fwd_byte_en", fwd_byte_en, q[$].be);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wb_en"}, wb_en, 0);
        check({tag, "_wb_addr"}, wb_addr, 0);
        check({tag, "_wb_data"}, wb_data, 0);
        check({tag, "_wb_be"}, wb_byte_en, 0);
        check({tag, "_fwd_valid"}, fwd_valid, 0);
        check({tag, "_fwd_rd"}, fwd_rd, 0);
        check({tag, "_fwd_data"}, fwd_data, 0);
        check({tag, "_fwd_be"}, fwd_byte_en, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    // One clock: drive at negedge, check against the model, advance the model.
    task automatic step(input logic v, input logic [63:0] d, input logic [4:0] rd,
                        input logic we, input logic [2:0] ppp, input logic st);
        logic acc;
        logic pop;
        ent_t e;
        @(negedge clk);
        in_valid = v; in_data = d; in_rd = rd; in_wren = we; in_ppp = ppp; wb_stall = st;
        #1;
        check_model();
        obs_wb_en = wb_en; obs_wb_addr = wb_addr; obs_wb_data = wb_data; obs_wb_be = wb_byte_en;
        acc = v && (q.size() != 2);
        pop = (q.size() != 0) && !st;
        if (pop) void'(q.pop_front());
        if (acc && we && (model_mask(ppp) != 8'h00)) begin
            e.rd = rd; e.data = d; e.be = model_mask(ppp);
            q.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic st);
        step(1'b0, 64'h0, 5'd0, 1'b0, 3'd0, st);
    endtask

    initial begin
        logic [63:0] da;
        logic [63:0] db;

        vecs[0] = '{3'b000, 1'b1, 8'hFF, 1'b1};
        vecs[1] = '{3'b001, 1'b1, 8'hF0, 1'b1};
        vecs[2] = '{3'b010, 1'b1, 8'h0F, 1'b1};
        vecs[3] = '{3'b011, 1'b1, 8'hAA, 1'b1};
        vecs[4] = '{3'b100, 1'b1, 8'h55, 1'b1};
        vecs[5] = '{3'b101, 1'b1, 8'h00, 1'b0};
        vecs[6] = '{3'b111, 1'b1, 8'h00, 1'b0};
        vecs[7] = '{3'b000, 1'b0, 8'h00, 1'b0};

        #1 reset = 1'b1;
        #1 check_all_zero("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single full-width write
        step(1'b1, 64'h0123456789ABCDEF, 5'd7, 1'b1, 3'd0, 1'b0);
        idle(1'b0);
        check("single_wb_en", obs_wb_en, 1);
        check("single_wb_addr", obs_wb_addr, 7);
        check("single_wb_data", obs_wb_data, 64'h0123456789ABCDEF);
        check("single_wb_be", obs_wb_be, 8'hFF);
        check("single_count_after", count, 0);

        // Participation decode table
        for (int i = 0; i < 8; i++) begin
            step(1'b1, {$urandom, $urandom}, 5'd3, vecs[i].wren, vecs[i].ppp, 1'b0);
            check($sformatf("ppp%0d_count", i), count, vecs[i].store);
            idle(1'b0);
            check($sformatf("ppp%0d_wb_en", i), obs_wb_en, vecs[i].store);
            if (vecs[i].store)
                check($sformatf("ppp%0d_be", i), obs_wb_be, vecs[i].be);
        end

        // Stall and fill
        step(1'b1, 64'h1111, 5'd1, 1'b1, 3'd0, 1'b1);
        step(1'b1, 64'h2222, 5'd2, 1'b1, 3'd0, 1'b1);
        check("fill_count", count, 2);
        check("fill_in_ready", in_ready, 0);
        step(1'b1, 64'h3333, 5'd3, 1'b1, 3'd0, 1'b1);
        check("fill_fwd_rd", fwd_rd, 2);
        check("fill_count_hold", count, 2);
        idle(1'b0);
        check("drain1_en", obs_wb_en, 1);
        check("drain1_addr", obs_wb_addr, 1);
        idle(1'b0);
        check("drain2_en", obs_wb_en, 1);
        check("drain2_addr", obs_wb_addr, 2);
        idle(1'b0);
        check("drain3_en", obs_wb_en, 0);

        // Same-cycle push and pop
        step(1'b1, 64'h4444, 5'd4, 1'b1, 3'd0, 1'b0);
        step(1'b1, 64'h5555, 5'd5, 1'b1, 3'd0, 1'b0);
        check("pp_wb_addr", obs_wb_addr, 4);
        check("pp_wb_en", obs_wb_en, 1);
        check("pp_count", count, 1);
        check("pp_fwd_rd", fwd_rd, 5);
        idle(1'b0);

        // Forwarding hazard: two partial writes to the same register
        da = 64'hAAAA_0000_AAAA_0000;
        db = 64'hBBBB_BBBB_CCCC_CCCC;
        step(1'b1, da, 5'd9, 1'b1, 3'b001, 1'b1);
        step(1'b1, db, 5'd9, 1'b1, 3'b010, 1'b1);
        check("haz_fwd_data", fwd_data, db);
        check("haz_fwd_be", fwd_byte_en, 8'h0F);
        check("haz_fwd_rd", fwd_rd, 9);
        idle(1'b0);
        check("haz_w1_data", obs_wb_data, da);
        check("haz_w1_be", obs_wb_be, 8'hF0);
        idle(1'b0);
        check("haz_w2_data", obs_wb_data, db);
        check("haz_w2_be", obs_wb_be, 8'h0F);
        idle(1'b0);

        // Reset mid-cycle with a full buffer
        step(1'b1, 64'h7777, 5'd11, 1'b1, 3'd0, 1'b1);
        step(1'b1, 64'h8888, 5'd12, 1'b1, 3'd0, 1'b1);
        check("prerst_count", count, 2);
        @(negedge clk);
        wb_stall = 1'b0;
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("midrst");
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        idle(1'b0);
        check("postrst_wb_en", obs_wb_en, 0);
        idle(1'b0);
        check("postrst_wb_en2", obs_wb_en, 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) < 3));
        end
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("final_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
